q_edge_counter: RTL and testbench

Q_EDGE_COUNTER -- requirements
Module: q_edge_counter

---
 rtl/q_edge_counter.sv | 155 +++++++++++++++
 tb/tb_q_edge_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/q_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : q_edge_counter
//  Description : Glitch filter and edge counter for a synchronous flop output.
//                q is accepted as changed only after FILT consecutive samples
//                that differ from the filtered value. Accepted edges produce
//                rise/fall pulses, a wrapping rising-edge count with sticky
//                overflow, and a one-deep valid/ready edge record buffer with
//                a sticky drop flag.
//  Ports       : clk, rst                - clock, sync active-high reset
//                q                       - monitored signal
//                en                      - enable counting / event records
//                clr                     - clear count, ovf, drop
//                q_filt, rise, fall      - filtered value and edge pulses
//                count, ovf              - rising-edge count, sticky wrap
//                evt_valid/evt_ready/evt_edge - edge record handshake
//                drop                    - sticky lost-record flag
//  Revision    : 1.0  initial release
// ============================================================================
module q_edge_counter #(
    parameter int CNT_W = 8,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q,
    input  logic             en,
    input  logic             clr,
    output logic             q_filt,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_edge,
    output logic             drop
);

    localparam logic [3:0] c_FILT = 4'(FILT);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_fcnt;
    logic [3:0]       w_fcnt_nxt;
    logic [3:0]       w_cnt_inc;
    logic             w_toggle;
    logic             w_rise_now;
    logic             w_evt_new;

    logic             r_q_filt;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_evt_valid;
    logic             r_evt_edge;
    logic             r_drop;

    // ------------------------------------------------------------------
    // Filter next-state: the sample on this edge counts toward FILT, so
    // with FILT=1 the first differing sample is accepted immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_STABLE;
        w_fcnt_nxt  = 4'd0;
        w_toggle    = 1'b0;
        w_cnt_inc   = (r_state == ST_STABLE) ? 4'd1 : (r_fcnt + 4'd1);
        if (q != r_q_filt) begin
            if (w_cnt_inc == c_FILT) begin
                w_toggle = 1'b1;
            end else begin
                w_state_nxt = ST_CHANGING;
                w_fcnt_nxt  = w_cnt_inc;
            end
        end
    end

    assign w_rise_now = w_toggle & ~r_q_filt;
    assign w_evt_new  = w_toggle & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STABLE;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Filtered value and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_filt <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_q_filt <= r_q_filt ^ w_toggle;
            r_rise   <= w_rise_now;
            r_fall   <= w_toggle & r_q_filt;
        end
    end

    // Rising-edge counter; clr wins over a coincident increment/wrap
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (en && w_rise_now) begin
            r_count <= r_count + 1'b1;
            if (&r_count) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // One-deep record buffer. A new record may load into a slot that is
    // draining this cycle; otherwise a full slot keeps its record stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_valid <= 1'b0;
            r_evt_edge  <= 1'b0;
        end else if (w_evt_new && (!r_evt_valid || evt_ready)) begin
            r_evt_valid <= 1'b1;
            r_evt_edge  <= ~r_q_filt;
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_drop <= 1'b0;
        end else if (w_evt_new && r_evt_valid && !evt_ready) begin
            r_drop <= 1'b1;
        end
    end

    assign q_filt    = r_q_filt;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign evt_valid = r_evt_valid;
    assign evt_edge  = r_evt_edge;
    assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_q_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_edge_counter
//  Description : Directed, table-driven bench for q_edge_counter with
//                FILT=2, CNT_W=4. Each record gives the inputs applied
//                before a rising edge and the outputs expected after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_q_edge_counter;

    localparam int CNT_W = 4;
    localparam int FILT  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             q;
    logic             en;
    logic             clr;
    logic             evt_ready;
    logic             q_filt;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             evt_valid;
    logic             evt_edge;
    logic             drop;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst, q, en, clr, rdy;
        logic       qf, ri, fa;
        logic [3:0] cnt;
        logic       ov, v, e, d;
    } vec_t;

    vec_t vecs[$];

    q_edge_counter #(.CNT_W(CNT_W), .FILT(FILT)) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .en        (en),
        .clr       (clr),
        .q_filt    (q_filt),
        .rise      (rise),
        .fall      (fall),
        .count     (count),
        .ovf       (ovf),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_edge  (evt_edge),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic add(input logic i_rst, i_q, i_en, i_clr, i_rdy,
                       input logic e_qf, e_ri, e_fa, input logic [3:0] e_cnt,
                       input logic e_ov, e_v, e_e, e_d);
        vec_t r;
        r.rst = i_rst; r.q = i_q; r.en = i_en; r.clr = i_clr; r.rdy = i_rdy;
        r.qf = e_qf; r.ri = e_ri; r.fa = e_fa; r.cnt = e_cnt;
        r.ov = e_ov; r.v = e_v; r.e = e_e; r.d = e_d;
        vecs.push_back(r);
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic i_rst, i_q, i_en, i_clr, i_rdy);
        @(negedge clk);
        rst = i_rst; q = i_q; en = i_en; clr = i_clr; evt_ready = i_rdy;
        @(posedge clk);
        #1;
    endtask

    // Packed order: q_filt rise fall count[3:0] ovf evt_valid evt_edge drop
    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {q_filt, rise, fall, count, ovf, evt_valid, evt_edge, drop};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got qf/ri/fa/cnt/ovf/v/e/d=%b/%b/%b/%0d/%b/%b/%b/%b required %b/%b/%b/%0d/%b/%b/%b/%b",
                     name, act[10], act[9], act[8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[10], exp[9], exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst = 1'b1; q = 1'b0; en = 1'b1; clr = 1'b0; evt_ready = 1'b1;

        //   rst q en clr rdy | qf ri fa cnt ov v  e  d
        add(1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);  // reset state
        add(0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);  // first differing sample
        add(0, 1, 1, 0, 1,   1, 1, 0, 1, 0, 1, 1, 0);  // accepted at 2nd edge
        add(0, 1, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);  // pulse ends, record drained
        add(0, 0, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);  // 0-glitch
        add(0, 1, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);  // glitch rejected
        add(0, 1, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);  // start of fall
        add(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 1, 0, 0);  // fall accepted
        add(0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0);  // 1-glitch
        add(0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 0, 0, 0);  // glitch rejected
        add(0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);  // backpressure: rise
        add(0, 1, 1, 0, 0,   1, 1, 0, 2, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0,   1, 0, 0, 2, 0, 1, 1, 0);  // then fall
        add(0, 0, 1, 0, 0,   0, 0, 1, 2, 0, 1, 1, 1);  // fall dropped, rise kept
        add(0, 0, 1, 0, 1,   0, 0, 0, 2, 0, 0, 1, 1);  // record transfers
        add(0, 1, 0, 0, 1,   0, 0, 0, 2, 0, 0, 1, 1);  // en=0 toggling
        add(0, 1, 0, 0, 1,   1, 1, 0, 2, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1,   1, 0, 0, 2, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1,   0, 0, 1, 2, 0, 0, 1, 1);
        add(0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 1, 0);  // clr count/drop
        add(0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0,   1, 1, 0, 1, 0, 1, 1, 0);  // pending record
        add(0, 0, 1, 0, 0,   1, 0, 0, 1, 0, 1, 1, 0);  // CHANGING + valid
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);  // reset wins
        add(1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);  // q=1 held in reset
        add(0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);  // treated as a change
        add(0, 1, 1, 0, 1,   1, 1, 0, 1, 0, 1, 1, 0);
        add(0, 1, 1, 0, 1,   1, 0, 0, 1, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].q, vecs[i].en, vecs[i].clr, vecs[i].rdy);
            check($sformatf("vec%0d", i),
                  {vecs[i].qf, vecs[i].ri, vecs[i].fa, vecs[i].cnt,
                   vecs[i].ov, vecs[i].v, vecs[i].e, vecs[i].d});
        end

        // Wrap sequence: clear, then 16 accepted rising edges.
        step(0, 1, 1, 1, 1);
        check("wrap_clr", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_cnt;
            exp_cnt = 4'(k % 16);
            step(0, 0, 1, 0, 1);
            step(0, 0, 1, 0, 1);
            step(0, 1, 1, 0, 1);
            step(0, 1, 1, 0, 1);
            check($sformatf("wrap_rise%0d", k),
                  {1'b1, 1'b1, 1'b0, exp_cnt, (k == 16), 1'b1, 1'b1, 1'b0});
        end
        step(0, 1, 1, 1, 1);
        check("ovf_clr", {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
